// File: rtl/radix4_output_serializer_pkg.sv
// Shared constants and helpers for the radix-4 output serializer.
//   R4_POINTS  : complex samples per butterfly group
//   SLOT_DEPTH : number of group slots in the ping-pong buffer
//   IDX_W      : width of the in-group sample index
package radix4_output_serializer_pkg;

    localparam int unsigned R4_POINTS  = 4;
    localparam int unsigned SLOT_DEPTH = 2;
    localparam int unsigned IDX_W      = 2;

    localparam logic [IDX_W-1:0] LAST_IDX   = 2'd3;
    localparam logic [1:0]       FULL_COUNT = 2'(SLOT_DEPTH);

    // Occupancy update: +1 on an accepted write, -1 on a completed group.
    function automatic logic [1:0] next_count(
        input logic [1:0] count,
        input logic       inc,
        input logic       dec
    );
        logic [1:0] result;
        case ({inc, dec})
            2'b10:   result = count + 2'd1;
            2'b01:   result = count - 2'd1;
            default: result = count;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/radix4_output_serializer_if.sv
// Bus bundle between the butterfly / downstream sink and the serializer.
//   done_in, in1r..in4i : butterfly result strobe and four complex results
//   out_valid/out_ready : serial stream handshake
//   out_r, out_i        : serial complex sample
//   out_idx, out_last   : position within group, last-beat flag
//   overflow, busy      : sticky dropped-group flag, buffer occupied
// master = producer/sink side, slave = serializer.
interface radix4_output_serializer_if #(
    parameter int WIDTH = 32
);
    import radix4_output_serializer_pkg::*;

    logic                    done_in;
    logic signed [WIDTH-1:0] in1r;
    logic signed [WIDTH-1:0] in1i;
    logic signed [WIDTH-1:0] in2r;
    logic signed [WIDTH-1:0] in2i;
    logic signed [WIDTH-1:0] in3r;
    logic signed [WIDTH-1:0] in3i;
    logic signed [WIDTH-1:0] in4r;
    logic signed [WIDTH-1:0] in4i;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_r;
    logic signed [WIDTH-1:0] out_i;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    overflow;
    logic                    busy;

    modport master (
        output done_in, in1r, in1i, in2r, in2i, in3r, in3i, in4r, in4i, out_ready,
        input  out_valid, out_r, out_i, out_idx, out_last, overflow, busy
    );

    modport slave (
        input  done_in, in1r, in1i, in2r, in2i, in3r, in3i, in4r, in4i, out_ready,
        output out_valid, out_r, out_i, out_idx, out_last, overflow, busy
    );

endinterface

// File: rtl/radix4_output_serializer_group_slot.sv
// r4_group_slot: one register bank holding a full butterfly group
// (4 complex words) with a write enable and an indexed read port.
//   clock, reset   : clock, async active-high reset
//   wr_en          : capture wr_re/wr_im (element 0 = butterfly output 1)
//   rd_idx         : element selected on rd_re/rd_im (straight from registers)
module r4_group_slot
    import radix4_output_serializer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [R4_POINTS-1:0][WIDTH-1:0]     wr_re,
    input  logic [R4_POINTS-1:0][WIDTH-1:0]     wr_im,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic [WIDTH-1:0]                    rd_re,
    output logic [WIDTH-1:0]                    rd_im
);

    logic [R4_POINTS-1:0][WIDTH-1:0] store_re_r;
    logic [R4_POINTS-1:0][WIDTH-1:0] store_im_r;

    // Group storage: whole group captured at once, held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            store_re_r <= '0;
            store_im_r <= '0;
        end else if (wr_en) begin
            store_re_r <= wr_re;
            store_im_r <= wr_im;
        end else begin
            store_re_r <= store_re_r;
            store_im_r <= store_im_r;
        end
    end

    assign rd_re = store_re_r[rd_idx];
    assign rd_im = store_im_r[rd_idx];

endmodule

// File: rtl/radix4_output_serializer.sv
// radix4_output_serializer: captures a 4-tuple of complex butterfly results
// on done_in into a two-slot ping-pong buffer and replays it one complex
// sample per accepted beat (order in1, in2, in3, in4).
//   clock, reset : clock, async active-high reset
//   bus (slave)  : butterfly inputs, serial valid/ready output, status flags
module radix4_output_serializer
    import radix4_output_serializer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    radix4_output_serializer_if.slave    bus
);

    logic [1:0]              count_r;
    logic [1:0]              count_nxt_s;
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    overflow_r;
    logic                    valid_s;
    logic                    fire_s;
    logic                    last_fire_s;
    logic                    accept_s;
    logic                    drop_s;
    logic                    wr_en0_s;
    logic                    wr_en1_s;
    logic [R4_POINTS-1:0][WIDTH-1:0] wr_re_s;
    logic [R4_POINTS-1:0][WIDTH-1:0] wr_im_s;
    logic [WIDTH-1:0]        slot0_re_s;
    logic [WIDTH-1:0]        slot0_im_s;
    logic [WIDTH-1:0]        slot1_re_s;
    logic [WIDTH-1:0]        slot1_im_s;

    assign wr_re_s = {bus.in4r, bus.in3r, bus.in2r, bus.in1r};
    assign wr_im_s = {bus.in4i, bus.in3i, bus.in2i, bus.in1i};

    // Handshake decode. A full buffer can still take a new group when the
    // head group completes in the same cycle, since that frees a slot.
    always_comb begin
        valid_s     = 1'b0;
        fire_s      = 1'b0;
        last_fire_s = 1'b0;
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        wr_en0_s    = 1'b0;
        wr_en1_s    = 1'b0;
        count_nxt_s = count_r;

        valid_s     = (count_r != 2'd0);
        fire_s      = valid_s & bus.out_ready;
        last_fire_s = fire_s & (idx_r == LAST_IDX);
        if (bus.done_in) begin
            if ((count_r < FULL_COUNT) || last_fire_s) begin
                accept_s = 1'b1;
                drop_s   = 1'b0;
            end else begin
                accept_s = 1'b0;
                drop_s   = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
        wr_en0_s    = accept_s & ~wr_ptr_r;
        wr_en1_s    = accept_s &  wr_ptr_r;
        count_nxt_s = next_count(count_r, accept_s, last_fire_s);
    end

    // Pointers, occupancy, in-group index and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            idx_r      <= 2'd0;
            count_r    <= 2'd0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (fire_s) begin
                // idx wraps 3 -> 0 naturally at the group boundary
                idx_r <= idx_r + 2'd1;
                if (last_fire_s) begin
                    rd_ptr_r <= ~rd_ptr_r;
                end
            end
            count_r <= count_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    r4_group_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en0_s),
        .wr_re  (wr_re_s),
        .wr_im  (wr_im_s),
        .rd_idx (idx_r),
        .rd_re  (slot0_re_s),
        .rd_im  (slot0_im_s)
    );

    r4_group_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en1_s),
        .wr_re  (wr_re_s),
        .wr_im  (wr_im_s),
        .rd_idx (idx_r),
        .rd_re  (slot1_re_s),
        .rd_im  (slot1_im_s)
    );

    assign bus.out_valid = valid_s;
    assign bus.busy      = valid_s;
    assign bus.out_r     = rd_ptr_r ? slot1_re_s : slot0_re_s;
    assign bus.out_i     = rd_ptr_r ? slot1_im_s : slot0_im_s;
    assign bus.out_idx   = idx_r;
    assign bus.out_last  = valid_s & (idx_r == LAST_IDX);
    assign bus.overflow  = overflow_r;

endmodule
